// File: rtl/bus_grant_arbiter_pkg.sv
// bus_grant_arbiter_pkg: shared state encoding, source count and pointer width for the bus arbiter.
package bus_grant_arbiter_pkg;
   localparam int SRC_N = 32;
   localparam int PTR_W = 5;
   typedef enum logic {IDLE, GRANTED} state_t;
   function automatic logic [PTR_W-1:0] onehot_idx(input logic [SRC_N-1:0] v);
      onehot_idx = '0;
      for (int i = 0; i < SRC_N; i++) if (v[i]) onehot_idx |= PTR_W'(i);
   endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit at or after ptr, wrapping 31 to 0.
module rr_priority_pick
   import bus_grant_arbiter_pkg::*;
(
   input  logic [SRC_N-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [SRC_N-1:0] pick,
   output logic             valid
);
   logic [PTR_W-1:0] j;
   assign valid = |req;
   // Walk from the farthest offset down so the nearest hit overwrites the rest.
   always_comb begin
      pick = '0;
      j = '0;
      for (int i = SRC_N-1; i >= 0; i--) begin
         j = ptr + PTR_W'(i);
         if (req[j]) begin
            pick = '0;
            pick[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin single-owner bus arbiter with forced release after MAX_HOLD cycles
// and a mandatory one-cycle idle turnaround between owners.
module bus_grant_arbiter
   import bus_grant_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 15
)(
   input  logic             clock,
   input  logic             clear,
   input  logic [SRC_N-1:0] Req,
   input  logic             Release,
   output logic [SRC_N-1:0] Grant,
   output logic             Busy,
   output logic             Timeout
);
   state_t           state, state_n;
   logic [PTR_W-1:0] ptr, ptr_n;
   logic [7:0]       hold, hold_n;
   logic [SRC_N-1:0] grant_n, pick;
   logic             valid, owner_req, hold_done, timeout_n;
   rr_priority_pick u_pick (
      .req   (Req),
      .ptr   (ptr),
      .pick  (pick),
      .valid (valid)
   );
   assign owner_req = |(Req & Grant);
   // hold counts completed grant cycles minus one, so Grant stays up exactly MAX_HOLD cycles.
   assign hold_done = hold == 8'(MAX_HOLD - 1);
   always_comb begin
      state_n = state;
      grant_n = Grant;
      ptr_n = ptr;
      hold_n = hold;
      timeout_n = 1'b0;
      if (state == IDLE) begin
         if (valid) begin
            state_n = GRANTED;
            grant_n = pick;
            hold_n = '0;
         end
      end else if (Release || !owner_req || hold_done) begin
         state_n = IDLE;
         grant_n = '0;
         ptr_n = PTR_W'(onehot_idx(Grant) + 1'b1);
         timeout_n = !Release && owner_req;
      end else begin
         hold_n = hold == 8'hff ? hold : hold + 8'd1;
      end
   end
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
         Grant <= '0;
         Busy <= 1'b0;
         Timeout <= 1'b0;
         ptr <= '0;
         hold <= '0;
      end else begin
         state <= state_n;
         Grant <= grant_n;
         Busy <= state_n == GRANTED;
         Timeout <= timeout_n;
         ptr <= ptr_n;
         hold <= hold_n;
      end
   end
endmodule

// File: doc/bus_grant_arbiter.md
BUS_GRANT_ARBITER -- requirements
Module: bus_grant_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 15, max cycles one grant may be held before forced release (1..255).
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: clear  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: Req  input  32  bus-source requests, bit i = source i wants to drive the bus.
REQ-005 SHALL have port: Release  input  1  current owner finished its transfer.
REQ-006 SHALL have port: Grant  output  32  registered grant, one-hot or all-zero; feeds the 32-to-5 bus encoder.
REQ-007 SHALL have port: Busy  output  1  high while a grant is held.
REQ-008 SHALL have port: Timeout  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-009 SHALL implement FSM states IDLE and GRANTED.
REQ-010 SHALL use a 5-bit round-robin pointer Ptr marking the highest-priority source.
REQ-011 In IDLE with Req nonzero, SHALL select the first set bit at index Ptr, Ptr+1, ... wrapping 31->0, load Grant with that one-hot bit at the next edge, and enter GRANTED.
REQ-012 In IDLE with Req zero, SHALL hold Grant=0 and stay in IDLE.
REQ-013 Grant latency SHALL be exactly one cycle from the Req-sampling edge.
REQ-014 In GRANTED, Grant SHALL stay constant regardless of other Req bits.
REQ-015 In GRANTED, SHALL return to IDLE with Grant=0 at the next edge if Release=1, or if the owner's Req bit is 0.
REQ-016 SHALL count cycles in GRANTED with a hold counter; once the count reaches MAX_HOLD and no release occurs, SHALL force return to IDLE, clear Grant, and pulse Timeout for one cycle.
REQ-017 On every exit from GRANTED, SHALL set Ptr to winner index + 1 modulo 32 (31 wraps to 0).
REQ-018 On exit from GRANTED, SHALL spend at least one cycle in IDLE with Grant=0 before the next grant (bus turnaround); Release coinciding with new requests does not shorten this.
REQ-019 Busy SHALL equal (state == GRANTED); Grant SHALL never have more than one bit set.
REQ-020 Release asserted while IDLE SHALL be ignored.
REQ-021 Hold counter SHALL clear on entry to GRANTED and saturate, never wrap.

Reset
REQ-022 On clear low, asynchronously: state=IDLE, Grant=0, Busy=0, Timeout=0, Ptr=0, hold counter=0.
REQ-023 Reset mid-grant SHALL drop Grant to 0 immediately, without waiting for a clock edge.
REQ-024 After clear rises, first grant SHALL follow REQ-011 with Ptr=0.

Structure
REQ-025 Shared package SHALL hold state encoding (IDLE, GRANTED), source count 32, and pointer width 5.
REQ-026 Rotating first-set-bit search SHALL be a sub-module rr_priority_pick (inputs Req and Ptr; outputs one-hot pick and any-valid).
REQ-027 Grant, Busy, and Timeout SHALL be driven directly from flops.

Verification
REQ-028 Reset, Req=32'h0000_0005 -> Grant=32'h0000_0001 one cycle later; Release -> Grant=0, Ptr=1; next grant 32'h0000_0004.
REQ-029 Ptr=31, Req=32'h8000_0001 -> Grant=32'h8000_0000; after release, Ptr=0 and next Grant=32'h0000_0001 (wrap).
REQ-030 MAX_HOLD=3, single Req held and no Release -> Grant held 3 cycles, then 0 with a 1-cycle Timeout pulse.
REQ-031 Owner drops Req while another Req is high -> Grant=0 for exactly one cycle, then the other source is granted.
REQ-032 clear pulsed low mid-grant -> Grant=0 with no clock edge; after clear rises, arbitration restarts from Ptr=0.
REQ-033 Random Req/Release over 10k cycles -> Grant always one-hot or zero, and no requester is starved for more than 32 grant cycles.
